// File: rtl/pipe_issue_if.sv
// Bus between the issue stage and its surroundings: run control, program
// loading, the instruction fields sent to the ALU pipe, and status counters.
interface pipe_issue_if;
    logic        start;
    logic [7:0]  start_pc;
    logic        hold;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [23:0] prog_data;
    logic [3:0]  func;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [7:0]  addr;
    logic        issue_valid;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] n_issued;
    logic [15:0] n_bubbles;

    modport master (
        output start, start_pc, hold, prog_we, prog_addr, prog_data,
        input  func, rd, rs1, rs2, addr, issue_valid, busy, halted, pc,
               n_issued, n_bubbles
    );

    modport slave (
        input  start, start_pc, hold, prog_we, prog_addr, prog_data,
        output func, rd, rs1, rs2, addr, issue_valid, busy, halted, pc,
               n_issued, n_bubbles
    );
endinterface

// File: rtl/pipe_issue.sv
// Fetch/issue stage for the 3-operand ALU pipe. Steps a PC through a loadable
// program memory, holds back instructions whose sources match recently issued
// destinations (the pipe has no forwarding), and substitutes bubbles that
// write the reserved register onto itself. Runs until a HALT word, drains,
// then stops.
module pipe_issue #(
    parameter int IMEM_DEPTH = 256,
    parameter int HAZ_DEPTH  = 2,
    parameter int NOP_REG    = 15,
    parameter int NOP_ADDR   = 255,
    parameter int DRAIN_CYC  = 3
) (
    input  logic        clk1,
    input  logic        rst,
    pipe_issue_if.slave bus
);
    localparam int PCW = $clog2(IMEM_DEPTH);
    localparam int DW  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [3:0]  NOP_R     = 4'(NOP_REG);
    localparam logic [7:0]  NOP_A     = 8'(NOP_ADDR);
    localparam logic [3:0]  HALT_FUNC = 4'hF;
    localparam logic [23:0] BUBBLE    = {4'd3, NOP_R, NOP_R, NOP_R, NOP_A};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    state_t                    state_q, state_n;
    logic [PCW-1:0]            pc_q, pc_n;
    logic [HAZ_DEPTH-1:0][3:0] hist_q, hist_n;
    logic [DW-1:0]             drain_q, drain_n;
    logic [15:0]               issued_q, issued_n;
    logic [15:0]               bubbles_q, bubbles_n;
    logic [23:0]               out_q, out_n;
    logic                      valid_q, valid_n;
    logic                      advance;

    logic [23:0] imem [IMEM_DEPTH];
    logic [23:0] word;
    logic        hazard;
    logic        is_halt;
    logic        busy;

    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign word    = imem[pc_q];
    assign is_halt = (word[23:20] == HALT_FUNC);

    // Program memory is only writable while no program is executing
    always_ff @(posedge clk1) begin
        if (bus.prog_we && !busy) begin
            imem[PCW'(bus.prog_addr)] <= bus.prog_data;
        end
    end

    // Raw hazard: a source of the fetched word matches a live recent destination
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (hist_q[i] != NOP_R &&
                (hist_q[i] == word[15:12] || hist_q[i] == word[11:8])) begin
                hazard = 1'b1;
            end
        end
    end

    // Next state and next registered outputs; every RUN/DRAIN edge issues one word
    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        hist_n    = hist_q;
        drain_n   = drain_q;
        issued_n  = issued_q;
        bubbles_n = bubbles_q;
        out_n     = BUBBLE;
        valid_n   = 1'b0;
        advance   = 1'b0;

        unique case (state_q)
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_n   = RUN;
                    pc_n      = PCW'(bus.start_pc);
                    issued_n  = '0;
                    bubbles_n = '0;
                    drain_n   = '0;
                    hist_n    = {HAZ_DEPTH{NOP_R}};
                end
            end
            RUN: begin
                advance = 1'b1;
                if (bus.hold) begin
                    out_n = BUBBLE;
                end else if (is_halt) begin
                    if (DRAIN_CYC > 1) begin
                        state_n = DRAIN;
                        drain_n = DW'(1);
                    end else begin
                        state_n = HALTED;
                    end
                end else if (!hazard) begin
                    out_n   = word;
                    valid_n = 1'b1;
                    pc_n    = pc_q + 1'b1;
                    if (issued_q != 16'hFFFF) begin
                        issued_n = issued_q + 16'd1;
                    end
                end
            end
            DRAIN: begin
                advance = 1'b1;
                if (drain_q == DW'(DRAIN_CYC - 1)) begin
                    state_n = HALTED;
                end else begin
                    drain_n = drain_q + 1'b1;
                end
            end
        endcase

        if (advance) begin
            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                hist_n[i] = hist_q[i-1];
            end
            hist_n[0] = out_n[19:16];
            if (!valid_n && bubbles_q != 16'hFFFF) begin
                bubbles_n = bubbles_q + 16'd1;
            end
        end
    end

    // State and output registers; reset aborts any run and shows the bubble at once
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            hist_q    <= {HAZ_DEPTH{NOP_R}};
            drain_q   <= '0;
            issued_q  <= '0;
            bubbles_q <= '0;
            out_q     <= BUBBLE;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            hist_q    <= hist_n;
            drain_q   <= drain_n;
            issued_q  <= issued_n;
            bubbles_q <= bubbles_n;
            out_q     <= out_n;
            valid_q   <= valid_n;
        end
    end

    assign bus.func        = out_q[23:20];
    assign bus.rd          = out_q[19:16];
    assign bus.rs1         = out_q[15:12];
    assign bus.rs2         = out_q[11:8];
    assign bus.addr        = out_q[7:0];
    assign bus.issue_valid = valid_q;
    assign bus.busy        = busy;
    assign bus.halted      = (state_q == HALTED);
    assign bus.pc          = 8'(pc_q);
    assign bus.n_issued    = issued_q;
    assign bus.n_bubbles   = bubbles_q;
endmodule

// File: tb/tb_pipe_issue.sv
// Bench for pipe_issue: a queue-based reference model tracks what each edge
// must issue, one compare process checks it every cycle, and directed
// scenarios pin the model with hand-computed literals.
module tb_pipe_issue;
    localparam logic [23:0] BUBBLE_WORD = 24'h3FFFFF;
    localparam int          DRAIN_CYC   = 3;

    logic clk1 = 1'b0;
    logic rst;

    pipe_issue_if bus();

    pipe_issue dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    // Free-running clock
    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    bit compare_en = 1'b0;

    logic [23:0] mmem [256];
    logic [3:0]  hist [$];
    logic        m_run, m_drain, m_halted;
    int          m_drain_left;
    logic [7:0]  m_pc;
    logic [15:0] m_issued, m_bubbles;
    logic [23:0] m_word;
    logic        m_valid;

    task automatic check_output(input string name, input logic [47:0] actual,
                                input logic [47:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic model_hazard(input logic [3:0] a, input logic [3:0] b);
        foreach (hist[i]) begin
            if (hist[i] != 4'hF && (hist[i] == a || hist[i] == b)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_drain = 0; m_halted = 0; m_drain_left = 0;
        m_pc = 8'd0; m_issued = 16'd0; m_bubbles = 16'd0;
        m_word = BUBBLE_WORD; m_valid = 0;
        hist = '{4'hF, 4'hF};
    endtask

    task automatic model_step();
        logic [23:0] w;
        logic        was_busy;
        was_busy = m_run || m_drain;
        m_word   = BUBBLE_WORD;
        m_valid  = 1'b0;
        if (m_run) begin
            w = mmem[m_pc];
            if (bus.hold) begin
            end else if (w[23:20] == 4'hF) begin
                m_run        = 0;
                m_drain      = 1;
                m_drain_left = DRAIN_CYC - 1;
            end else if (!model_hazard(w[15:12], w[11:8])) begin
                m_word  = w;
                m_valid = 1'b1;
                m_pc    = m_pc + 8'd1;
                if (m_issued != 16'hFFFF) m_issued = m_issued + 16'd1;
            end
        end else if (m_drain) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_drain  = 0;
                m_halted = 1;
            end
        end else if (bus.start) begin
            m_run = 1; m_halted = 0; m_pc = bus.start_pc;
            m_issued = 16'd0; m_bubbles = 16'd0;
            hist = '{4'hF, 4'hF};
        end
        if (was_busy) begin
            hist.push_front(m_word[19:16]);
            if (hist.size() > 2) void'(hist.pop_back());
            if (!m_valid && m_bubbles != 16'hFFFF) m_bubbles = m_bubbles + 16'd1;
        end
        if (bus.prog_we && !was_busy) mmem[bus.prog_addr] = bus.prog_data;
    endtask

    // Reference model advances on the same edges as the design
    always @(posedge clk1 or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk1) begin
        if (compare_en && !rst) begin
            if (bus.issue_valid === 1'b1) valid_seen++;
            check_output("instr", {24'd0, bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr}, {24'd0, m_word});
            check_output("issue_valid", {47'd0, bus.issue_valid}, {47'd0, m_valid});
            check_output("busy_halted", {46'd0, bus.busy, bus.halted}, {46'd0, m_run || m_drain, m_halted});
            check_output("pc", {40'd0, bus.pc}, {40'd0, m_pc});
            check_output("counters", {16'd0, bus.n_issued, bus.n_bubbles}, {16'd0, m_issued, m_bubbles});
        end
    end

    // One clock of inputs; start and prog_we are pulses, hold is a level
    task automatic apply_stimulus(input logic we, input logic [7:0] a, input logic [23:0] d,
                                  input logic st, input logic [7:0] spc, input logic hd);
        bus.prog_we = we; bus.prog_addr = a; bus.prog_data = d;
        bus.start = st; bus.start_pc = spc; bus.hold = hd;
        @(posedge clk1);
        #1;
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [23:0] d);
        apply_stimulus(1'b1, a, d, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic wait_halted(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.halted === 1'b1) break;
            @(posedge clk1);
            #1;
        end
        check_output("halt_reached", {47'd0, bus.halted}, 48'd1);
    endtask

    task automatic check_idle_reset_values();
        check_output("rst_instr", {24'd0, bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr}, {24'd0, BUBBLE_WORD});
        check_output("rst_flags", {45'd0, bus.issue_valid, bus.busy, bus.halted}, 48'd0);
        check_output("rst_pc", {40'd0, bus.pc}, 48'd0);
        check_output("rst_counters", {16'd0, bus.n_issued, bus.n_bubbles}, 48'd0);
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int base;
        rst = 1'b0;
        bus.start = 0; bus.start_pc = 0; bus.hold = 0;
        bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
        #1 rst = 1'b1;
        #2;
        check_idle_reset_values();
        @(posedge clk1);
        #1 rst = 1'b0;
        compare_en = 1'b1;

        $display("[TB] basic run");
        load(8'd0, 24'h012300);
        load(8'd1, 24'h145600);
        load(8'd2, 24'hF00000);
        base = valid_seen;
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b1, 8'd0, 1'b0);
        wait_halted(20);
        check_output("basic_issued", {32'd0, bus.n_issued}, 48'd2);
        check_output("basic_bubbles", {32'd0, bus.n_bubbles}, 48'd3);
        check_output("basic_valid_cycles", 48'(valid_seen - base), 48'd2);

        $display("[TB] raw hazard");
        load(8'd1, 24'h141600);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b1, 8'd0, 1'b0);
        wait_halted(20);
        check_output("raw_issued", {32'd0, bus.n_issued}, 48'd2);
        check_output("raw_bubbles", {32'd0, bus.n_bubbles}, 48'd5);

        $display("[TB] hold");
        load(8'd1, 24'h145600);
        load(8'd2, 24'h278910);
        load(8'd3, 24'h4ABC20);
        load(8'd4, 24'hF00000);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b1, 8'd0, 1'b0);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b1);
        check_output("hold_pc", {40'd0, bus.pc}, 48'd2);
        check_output("hold_bubbles", {32'd0, bus.n_bubbles}, 48'd4);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0);
        check_output("hold_resume_rd", {44'd0, bus.rd}, 48'd7);
        wait_halted(30);
        check_output("hold_issued", {32'd0, bus.n_issued}, 48'd4);
        check_output("hold_total_bubbles", {32'd0, bus.n_bubbles}, 48'd7);

        $display("[TB] pc wrap with start and write together");
        load(8'd255, 24'h012300);
        apply_stimulus(1'b1, 8'd0, 24'hF00000, 1'b1, 8'd255, 1'b0);
        wait_halted(20);
        check_output("wrap_pc", {40'd0, bus.pc}, 48'd0);
        check_output("wrap_issued", {32'd0, bus.n_issued}, 48'd1);

        $display("[TB] async reset mid-run");
        load(8'd0, 24'h012300);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b1, 8'd0, 1'b0);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_idle_reset_values();
        @(posedge clk1);
        #1 rst = 1'b0;
        base = valid_seen;
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b1, 8'd0, 1'b0);
        wait_halted(30);
        check_output("rerun_issued", {32'd0, bus.n_issued}, 48'd4);
        check_output("rerun_bubbles", {32'd0, bus.n_bubbles}, 48'd3);
        check_output("rerun_valid_cycles", 48'(valid_seen - base), 48'd4);

        $display("[TB] write and start while busy");
        load(8'd2, 24'hF00000);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b1, 8'd0, 1'b0);
        apply_stimulus(1'b1, 8'd1, 24'h1AB000, 1'b1, 8'h80, 1'b0);
        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0);
        check_output("busy_write_word", {24'd0, bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr}, 48'h145600);
        check_output("busy_write_valid", {47'd0, bus.issue_valid}, 48'd1);
        wait_halted(20);
        check_output("busy_write_issued", {32'd0, bus.n_issued}, 48'd2);

        apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0);
        compare_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
